// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller that shares one external 4-to-7 segment
//   decoder across NUM_DIGITS digit positions. A one-entry pending register
//   accepts new display words. Each word is copied into the displayed (shadow)
//   register only at a frame wrap, or at any time while idle, so a frame never
//   shows a mix of old and new digits. Each digit is lit for DWELL_CYCLES
//   clocks and then followed by BLANK_CYCLES dark clocks, which suppresses
//   ghosting.
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   enable       1 = scan, 0 = go dark (IDLE)
//   load_valid / load_ready / load_data   display word handshake, digit 0 = LSN
//   blank_mask   bit k forces digit k dark; applied live
//   nibble_out   registered nibble to the external decoder
//   seg_in       decoder output, combinational from nibble_out
//   seg_out      segments to the display; zero when no digit is enabled
//   digit_en     one-hot digit enable
//   frame_done   one-cycle pulse at each frame wrap
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              nibble_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                       state;
    logic [NUM_DIGITS-1:0][3:0]   shadow, pending, shadow_nxt;
    logic                         pending_full;
    logic [IW-1:0]                idx, idx_inc;
    logic [TW-1:0]                timer;
    logic [NUM_DIGITS-1:0]        digit_sel;
    logic                         dwell_last, blank_last, advance, wrap, accept, copy;

    always_comb begin
        dwell_last = (timer == TW'(DWELL_CYCLES - 1));
        // When BLANK_CYCLES is 0 the BLANK state is unreachable, so this
        // compare against all-ones is never used.
        blank_last = (timer == TW'(BLANK_CYCLES - 1));
        idx_inc    = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        // A disable takes priority over advancing, so a partial frame can
        // never wrap and never copies a pending word.
        advance    = enable & (((state == SHOW) & dwell_last & (BLANK_CYCLES == 0)) |
                               ((state == BLANK) & blank_last));
        wrap       = advance & (idx == IW'(NUM_DIGITS - 1));
        accept     = load_valid & ~pending_full;
        copy       = pending_full & (wrap | (state == IDLE));
        // The nibble latched on a wrap edge must come from the word being
        // copied in on that edge.
        shadow_nxt = copy ? pending : shadow;
    end

    assign load_ready = ~pending_full;
    assign digit_en   = digit_sel & ~blank_mask;
    assign seg_out    = (|digit_en) ? seg_in : 7'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            timer        <= '0;
            shadow       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            nibble_out   <= 4'd0;
            digit_sel    <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // accept needs an empty pending register and copy needs a full
            // one, so they never fire on the same edge.
            if (accept) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end
            if (copy) begin
                shadow       <= pending;
                pending_full <= 1'b0;
            end
            case (state)
                IDLE: begin
                    idx       <= '0;
                    timer     <= '0;
                    digit_sel <= '0;
                    if (enable) begin
                        state      <= SHOW;
                        digit_sel  <= NUM_DIGITS'(1);
                        nibble_out <= shadow_nxt[0];
                    end
                end
                SHOW: begin
                    if (!enable) begin
                        state     <= IDLE;
                        idx       <= '0;
                        timer     <= '0;
                        digit_sel <= '0;
                    end else if (dwell_last) begin
                        timer <= '0;
                        if (BLANK_CYCLES > 0) begin
                            state     <= BLANK;
                            digit_sel <= '0;
                        end else begin
                            idx        <= idx_inc;
                            digit_sel  <= NUM_DIGITS'(1) << idx_inc;
                            nibble_out <= shadow_nxt[idx_inc];
                            frame_done <= wrap;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BLANK: begin
                    if (!enable) begin
                        state     <= IDLE;
                        idx       <= '0;
                        timer     <= '0;
                        digit_sel <= '0;
                    end else if (blank_last) begin
                        state      <= SHOW;
                        timer      <= '0;
                        idx        <= idx_inc;
                        digit_sel  <= NUM_DIGITS'(1) << idx_inc;
                        nibble_out <= shadow_nxt[idx_inc];
                        frame_done <= wrap;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
//   Testbench for seven_seg_scan_ctrl. The main instance uses 4 digits, a
//   dwell of 4 and a blank of 2. A second instance uses a blank of 0. The
//   reference model tracks the number of cycles since scanning started and
//   derives the digit and slot arithmetically. It keeps the pending and shown
//   words as plain variables.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4, D = 4, B = 2;
    localparam int SLOT = D + B, FRAME = N * SLOT;

    logic        clk = 0, rst_n = 0;
    logic        enable = 0, load_valid = 0, load_ready, frame_done;
    logic [15:0] load_data = 0;
    logic [3:0]  blank_mask = 0, nibble_out, digit_en;
    logic [6:0]  seg_in, seg_out;

    logic        en0 = 0, lv0 = 0, rdy0, fd0;
    logic [15:0] ld0 = 0;
    logic [3:0]  nib0, den0;
    logic [6:0]  si0, so0;

    int tests = 0, fails = 0;

    // Reference model state
    bit          m_run;
    int          m_k;
    logic [15:0] m_shadow, m_pend;
    bit          m_full;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .blank_mask(blank_mask),
        .nibble_out(nibble_out), .seg_in(seg_in), .seg_out(seg_out),
        .digit_en(digit_en), .frame_done(frame_done));

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .load_valid(lv0),
        .load_ready(rdy0), .load_data(ld0), .blank_mask(4'b0000),
        .nibble_out(nib0), .seg_in(si0), .seg_out(so0),
        .digit_en(den0), .frame_done(fd0));

    // Stand-in decoder: never zero, so a dark seg_out is always distinguishable.
    assign seg_in = {3'b101, nibble_out};
    assign si0    = {3'b101, nib0};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_k = 0; m_shadow = 0; m_pend = 0; m_full = 0;
    endtask

    // Applies one clock edge to the model, using the inputs held before the edge.
    task automatic model_edge();
        bit acc, cp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = load_valid && !m_full;
        cp  = 0;
        if (!m_run) begin
            cp = m_full;
            if (enable) begin m_run = 1; m_k = 0; end
        end else if (!enable) begin
            m_run = 0; m_k = 0;
        end else begin
            m_k++;
            if (m_k % FRAME == 0) cp = m_full;
        end
        if (cp) begin m_shadow = m_pend; m_full = 0; end
        if (acc) begin m_pend = load_data; m_full = 1; end
    endtask

    task automatic check_outputs();
        int dig, slot;
        bit show;
        logic [3:0] exp_en, exp_nib;
        dig = (m_k / SLOT) % N;
        slot = m_k % SLOT;
        show = m_run && (slot < D);
        exp_nib = m_shadow[dig*4 +: 4];
        exp_en = (show && !blank_mask[dig]) ? 4'(1 << dig) : 4'b0;
        chk("digit_en", 32'(digit_en), 32'(exp_en));
        chk("frame_done", 32'(frame_done), 32'(m_run && m_k > 0 && (m_k % FRAME == 0)));
        chk("load_ready", 32'(load_ready), 32'(!m_full));
        if (show) chk("nibble_out", 32'(nibble_out), 32'(exp_nib));
        chk("seg_out", 32'(seg_out), (exp_en != 0) ? 32'({3'b101, exp_nib}) : 32'd0);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load(input logic [15:0] w);
        load_valid = 1; load_data = w;
        cycle();
        load_valid = 0; load_data = $urandom;
    endtask

    initial begin
        int n;
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digit_en", 32'(digit_en), 0);
        chk("rst_nibble", 32'(nibble_out), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_load_ready", 32'(load_ready), 1);
        rst_n = 1;
        repeat (3) cycle();

        // Load while idle, then enable: two full frames of 3A51
        load(16'h3A51);
        cycle();
        chk("t2_shadow_idle_copy", 32'(load_ready), 1);
        enable = 1;
        repeat (2 * FRAME) cycle();

        // Mid-frame load, second offer while full must be dropped
        repeat (7) cycle();
        load(16'hBEEF);
        load_valid = 1; load_data = 16'h1234;
        repeat (3) cycle();
        load_valid = 0;
        repeat (FRAME + 4) cycle();

        // Mask digit 2 for a full frame
        blank_mask = 4'b0100;
        repeat (FRAME + 2) cycle();
        blank_mask = 4'b0000;

        // Drop enable in the blank gap after digit 2, then restart
        n = 0;
        while (!(m_run && (m_k % SLOT) >= D && ((m_k / SLOT) % N) == 2) && n < 100) begin
            cycle(); n++;
        end
        chk("t6_reached_blank2", 32'(n < 100), 1);
        enable = 0;
        repeat (5) cycle();
        enable = 1;
        repeat (FRAME + 3) cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = $urandom;
            blank_mask = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
            enable     = ($urandom_range(0, 40) != 0);
            cycle();
        end
        load_valid = 0; blank_mask = 0; enable = 1;

        // Reset pulse in the middle of a SHOW slot
        n = 0;
        while (!(m_run && (m_k % SLOT) == 1) && n < 100) begin
            cycle(); n++;
        end
        chk("t1_reached_show", 32'(n < 100), 1);
        rst_n = 0; enable = 0;
        model_reset();
        #1;
        chk("t1_digit_en", 32'(digit_en), 0);
        chk("t1_seg_out", 32'(seg_out), 0);
        chk("t1_frame_done", 32'(frame_done), 0);
        chk("t1_load_ready", 32'(load_ready), 1);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (6) cycle();

        // Zero-blank instance: back-to-back digits, 16-clock frame
        lv0 = 1; ld0 = 16'h4321;
        @(posedge clk); #1;
        lv0 = 0;
        @(posedge clk); #1;
        en0 = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 3 * N * D; k++) begin
            @(negedge clk);
            chk("b0_digit_en", 32'(den0), 32'(1 << ((k / D) % N)));
            chk("b0_frame_done", 32'(fd0), 32'(k > 0 && (k % (N * D)) == 0));
            chk("b0_nibble", 32'(nib0), 32'((k / D) % N + 1));
            @(posedge clk); #1;
        end
        en0 = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
